// File: rtl/snake_motion_ctrl.sv
// snake_motion_ctrl: head motion, length-based tick rate and buffered turns.
// Define SNAKE_WRAP_EN to wrap at the playfield edges instead of colliding.
module snake_motion_ctrl #(
  parameter int COORD_W = 11,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int START_X = 240,
  parameter int START_Y = 350,
  parameter int STEP    = 1,
  parameter int LEN_W   = 8,
  parameter int LEN_TH1 = 20,
  parameter int LEN_TH2 = 50,
  parameter int PERIOD0 = 2000000,
  parameter int PERIOD1 = 900000,
  parameter int PERIOD2 = 400000,
  parameter int TICK_W  = 28,
  parameter int QDEPTH  = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iGameOver,
  input  logic               iPause,
  input  logic               iWest,
  input  logic               iEast,
  input  logic               iNorth,
  input  logic               iSouth,
  input  logic [LEN_W-1:0]   iSnakeLength,
  output logic [COORD_W-1:0] oSnakeLocationX,
  output logic [COORD_W-1:0] oSnakeLocationY,
  output logic [1:0]         oHeading,
  output logic               oIconTick,
  output logic               oWallHit,
  output logic               oQueueFull
);

  localparam int XW = COORD_W + 1;
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [XW-1:0] X_LIM  = XW'(X_MAX);
  localparam logic [XW-1:0] Y_LIM  = XW'(Y_MAX);
  localparam logic [XW-1:0] STEP_C = XW'(STEP);
`ifdef SNAKE_WRAP_EN
  localparam logic [XW-1:0] X_SPAN = XW'(X_MAX + 1);
  localparam logic [XW-1:0] Y_SPAN = XW'(Y_MAX + 1);
`endif

  localparam logic [TICK_W-1:0] LAST0 = TICK_W'(PERIOD0 - 1);
  localparam logic [TICK_W-1:0] LAST1 = TICK_W'(PERIOD1 - 1);
  localparam logic [TICK_W-1:0] LAST2 = TICK_W'(PERIOD2 - 1);

  localparam logic [LEN_W-1:0] TH1 = LEN_W'(LEN_TH1);
  localparam logic [LEN_W-1:0] TH2 = LEN_W'(LEN_TH2);

  localparam logic [PW-1:0] PTR_END = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] Q_FULL  = CW'(QDEPTH);

  localparam logic [1:0] H_EAST  = 2'd0;
  localparam logic [1:0] H_WEST  = 2'd1;
  localparam logic [1:0] H_NORTH = 2'd2;
  localparam logic [1:0] H_SOUTH = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          level_q, level_d;
  logic                tick_q, tick_d;
  logic                wall_q, wall_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic [1:0]          head_q, head_d;
  logic [3:0]          btn_q;
  logic [1:0]          q_mem_q [QDEPTH];
  logic [1:0]          q_mem_d [QDEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       q_cnt_q, q_cnt_d;

  logic [3:0]          btn;
  logic [3:0]          rise;
  logic                req_vld;
  logic [1:0]          req_dir;
  logic                q_empty;
  logic                q_full;
  logic [PW-1:0]       tail_ptr;
  logic [1:0]          ref_dir;
  logic                push;
  logic                pop;
  logic                step;
  logic [TICK_W-1:0]   last;
  logic [1:0]          len_lvl;
  logic [1:0]          dir;
  logic                hit;
  logic [XW-1:0]       x_ext;
  logic [XW-1:0]       y_ext;

  // bit0 West, bit1 East, bit2 South, bit3 North (priority order)
  assign btn  = {iNorth, iSouth, iEast, iWest};
  assign rise = btn & ~btn_q;

  assign q_empty  = (q_cnt_q == '0);
  assign q_full   = (q_cnt_q == Q_FULL);
  assign tail_ptr = (wr_ptr_q == '0) ? PTR_END : wr_ptr_q - 1'b1;
  assign ref_dir  = q_empty ? head_q : q_mem_q[tail_ptr];

  assign step = (state_q == ST_RUN) && !iPause && !iGameOver && (cnt_q == last);
  assign pop  = step && !q_empty;
  assign dir  = pop ? q_mem_q[rd_ptr_q] : head_q;

  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};

  // Highest-priority new button press this clock
  always_comb begin
    req_vld = |rise;
    req_dir = H_NORTH;
    if (rise[0])      req_dir = H_WEST;
    else if (rise[1]) req_dir = H_EAST;
    else if (rise[2]) req_dir = H_SOUTH;
    else              req_dir = H_NORTH;
  end

  // Accept a turn only if it changes axis relative to the last queued heading
  always_comb begin
    push = req_vld && (state_q != ST_HALT) && !q_full &&
           (req_dir[1] != ref_dir[1]);
  end

  // Speed level from body length, and terminal count of the current level
  always_comb begin
    len_lvl = 2'd0;
    unique case (1'b1)
      (iSnakeLength < TH1):  len_lvl = 2'd0;
      (iSnakeLength >= TH2): len_lvl = 2'd2;
      default:               len_lvl = 2'd1;
    endcase
    last = LAST0;
    unique case (level_q)
      2'd1:    last = LAST1;
      2'd2:    last = LAST2;
      default: last = LAST0;
    endcase
  end

  // Turn queue pointers, occupancy and storage
  always_comb begin
    q_mem_d  = q_mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    q_cnt_d  = q_cnt_q;
    if (push) begin
      q_mem_d[wr_ptr_q] = req_dir;
      wr_ptr_d = (wr_ptr_q == PTR_END) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_END) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   q_cnt_d = q_cnt_q + 1'b1;
      2'b01:   q_cnt_d = q_cnt_q - 1'b1;
      default: q_cnt_d = q_cnt_q;
    endcase
  end

  // Next head position; extra bit keeps edge checks free of overflow
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    hit = 1'b0;
    if (step) begin
      unique case (dir)
        H_EAST: begin
          if ((x_ext + STEP_C) > X_LIM) begin
`ifdef SNAKE_WRAP_EN
            x_d = COORD_W'(x_ext + STEP_C - X_SPAN);
`else
            hit = 1'b1;
`endif
          end else begin
            x_d = COORD_W'(x_ext + STEP_C);
          end
        end
        H_WEST: begin
          if (x_ext < STEP_C) begin
`ifdef SNAKE_WRAP_EN
            x_d = COORD_W'(x_ext + X_SPAN - STEP_C);
`else
            hit = 1'b1;
`endif
          end else begin
            x_d = COORD_W'(x_ext - STEP_C);
          end
        end
        H_NORTH: begin
          if (y_ext < STEP_C) begin
`ifdef SNAKE_WRAP_EN
            y_d = COORD_W'(y_ext + Y_SPAN - STEP_C);
`else
            hit = 1'b1;
`endif
          end else begin
            y_d = COORD_W'(y_ext - STEP_C);
          end
        end
        H_SOUTH: begin
          if ((y_ext + STEP_C) > Y_LIM) begin
`ifdef SNAKE_WRAP_EN
            y_d = COORD_W'(y_ext + STEP_C - Y_SPAN);
`else
            hit = 1'b1;
`endif
          end else begin
            y_d = COORD_W'(y_ext + STEP_C);
          end
        end
      endcase
    end
  end

  // Run/pause/halt control, tick counter and registered pulse outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    tick_d  = 1'b0;
    wall_d  = wall_q;
    head_d  = head_q;
    unique case (state_q)
      ST_RUN: begin
        if (iGameOver) begin
          state_d = ST_HALT;
        end else if (iPause) begin
          state_d = ST_PAUSE;
        end else if (step) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          level_d = len_lvl;
          head_d  = dir;
          if (hit) begin
            state_d = ST_HALT;
            wall_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (iGameOver)   state_d = ST_HALT;
        else if (!iPause) state_d = ST_RUN;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // State registers, asynchronously reset to the start position
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      level_q  <= 2'd0;
      tick_q   <= 1'b0;
      wall_q   <= 1'b0;
      x_q      <= COORD_W'(START_X);
      y_q      <= COORD_W'(START_Y);
      head_q   <= H_EAST;
      btn_q    <= '0;
      q_mem_q  <= '{default: 2'd0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      tick_q   <= tick_d;
      wall_q   <= wall_d;
      x_q      <= x_d;
      y_q      <= y_d;
      head_q   <= head_d;
      btn_q    <= btn;
      q_mem_q  <= q_mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      q_cnt_q  <= q_cnt_d;
    end
  end

  assign oSnakeLocationX = x_q;
  assign oSnakeLocationY = y_q;
  assign oHeading        = head_q;
  assign oIconTick       = tick_q;
  assign oWallHit        = wall_q;
  assign oQueueFull      = q_full;

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// tb_snake_motion_ctrl: table vectors, hand sequences and a random run
// compared every clock against a queue-based reference model.
module tb_snake_motion_ctrl;

  localparam int TP0  = 4;
  localparam int TP1  = 6;
  localparam int TP2  = 3;
  localparam int QD   = 2;
  localparam int XMAX = 639;
  localparam int YMAX = 479;
  localparam int MSTEP = 1;

  logic        Clock;
  logic        Reset;
  logic        iGameOver, iPause;
  logic        iWest, iEast, iNorth, iSouth;
  logic [7:0]  iSnakeLength;
  logic [10:0] oX, oY;
  logic [1:0]  oHead;
  logic        oTick, oWall, oFull;

  logic [10:0] x2, y2;
  logic [1:0]  head2;
  logic        tick2, wall2, full2;

  int n_cmp = 0;
  int n_err = 0;

  snake_motion_ctrl #(
    .PERIOD0(TP0), .PERIOD1(TP1), .PERIOD2(TP2), .QDEPTH(QD)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iGameOver(iGameOver), .iPause(iPause),
    .iWest(iWest), .iEast(iEast), .iNorth(iNorth), .iSouth(iSouth),
    .iSnakeLength(iSnakeLength),
    .oSnakeLocationX(oX), .oSnakeLocationY(oY),
    .oHeading(oHead), .oIconTick(oTick),
    .oWallHit(oWall), .oQueueFull(oFull)
  );

  snake_motion_ctrl #(
    .START_X(638), .STEP(2),
    .PERIOD0(TP0), .PERIOD1(TP1), .PERIOD2(TP2)
  ) dut_wall (
    .Clock(Clock), .Reset(Reset),
    .iGameOver(1'b0), .iPause(1'b0),
    .iWest(1'b0), .iEast(1'b0), .iNorth(1'b0), .iSouth(1'b0),
    .iSnakeLength(8'd0),
    .oSnakeLocationX(x2), .oSnakeLocationY(y2),
    .oHeading(head2), .oIconTick(tick2),
    .oWallHit(wall2), .oQueueFull(full2)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int m_x, m_y, m_head, m_cnt, m_lvl, m_tick, m_wall, m_state;
  int m_q[$];
  bit pw, pe, pn, ps;

  function automatic int per_of(int l);
    if (l == 0) return TP0;
    if (l == 1) return TP1;
    return TP2;
  endfunction

  function automatic int lvl_of(int len);
    if (len < 20) return 0;
    if (len < 50) return 1;
    return 2;
  endfunction

  task automatic m_reset();
    m_x = 240; m_y = 350; m_head = 0; m_cnt = 0; m_lvl = 0;
    m_tick = 0; m_wall = 0; m_state = 0;
    m_q.delete();
    pw = 0; pe = 0; pn = 0; ps = 0;
  endtask

  task automatic m_move();
    int nx, ny;
    nx = m_x; ny = m_y;
    case (m_head)
      0: nx = m_x + MSTEP;
      1: nx = m_x - MSTEP;
      2: ny = m_y - MSTEP;
      default: ny = m_y + MSTEP;
    endcase
    if (nx < 0 || nx > XMAX || ny < 0 || ny > YMAX) begin
`ifdef SNAKE_WRAP_EN
      m_x = (nx + XMAX + 1) % (XMAX + 1);
      m_y = (ny + YMAX + 1) % (YMAX + 1);
`else
      m_wall = 1;
      m_state = 2;
`endif
    end else begin
      m_x = nx;
      m_y = ny;
    end
  endtask

  task automatic m_step();
    int req, refd;
    bit accept;
    req = -1;
    if (iWest && !pw)       req = 1;
    else if (iEast && !pe)  req = 0;
    else if (iSouth && !ps) req = 3;
    else if (iNorth && !pn) req = 2;
    pw = iWest; pe = iEast; pn = iNorth; ps = iSouth;
    refd = (m_q.size() > 0) ? m_q[$] : m_head;
    accept = (req >= 0) && (m_state != 2) && (m_q.size() < QD) &&
             (req / 2 != refd / 2);
    m_tick = 0;
    if (m_state != 2) begin
      if (iGameOver) m_state = 2;
      else if (m_state == 1) begin
        if (!iPause) m_state = 0;
      end else if (iPause) m_state = 1;
      else if (m_cnt == per_of(m_lvl) - 1) begin
        m_cnt = 0;
        m_tick = 1;
        m_lvl = lvl_of(int'(iSnakeLength));
        if (m_q.size() > 0) m_head = m_q.pop_front();
        m_move();
      end else m_cnt++;
    end
    if (accept) m_q.push_back(req);
  endtask

  // Model advances on the same edges as the DUT
  always @(posedge Clock or posedge Reset) begin
    if (Reset) m_reset();
    else m_step();
  end

  // Continuous compare of every observable output
  always @(negedge Clock) begin
    if (!Reset) begin
      check("x", int'(oX), m_x);
      check("y", int'(oY), m_y);
      check("heading", int'(oHead), m_head);
      check("tick", int'(oTick), m_tick);
      check("wall", int'(oWall), m_wall);
      check("qfull", int'(oFull), (m_q.size() == QD) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic clr_in();
    iGameOver = 0; iPause = 0;
    iWest = 0; iEast = 0; iNorth = 0; iSouth = 0;
  endtask

  task automatic do_reset();
    @(negedge Clock); #2;
    Reset = 1'b1;
    clr_in();
    @(negedge Clock); #2;
    Reset = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!oTick && n < 100);
  endtask

  task automatic press(int d);
    case (d)
      0: iEast = 1;
      1: iWest = 1;
      2: iNorth = 1;
      default: iSouth = 1;
    endcase
    cyc(1);
    iEast = 0; iWest = 0; iNorth = 0; iSouth = 0;
  endtask

  typedef struct {
    int len;
    int per;
  } spd_vec_t;

  spd_vec_t vecs[6];

  initial begin
    int n, ticks;
    int lens[6];

    vecs[0] = '{len: 0,   per: TP0};
    vecs[1] = '{len: 19,  per: TP0};
    vecs[2] = '{len: 20,  per: TP1};
    vecs[3] = '{len: 49,  per: TP1};
    vecs[4] = '{len: 50,  per: TP2};
    vecs[5] = '{len: 255, per: TP2};
    lens = '{0, 19, 20, 49, 50, 255};

    Reset = 1'b0;
    iSnakeLength = 8'd0;
    clr_in();
    #1 Reset = 1'b1;
    do_reset();

    // reset state and edge behaviour of the STEP=2 instance
    check("rst_x", int'(oX), 240);
    check("rst_y", int'(oY), 350);
    check("rst_head", int'(oHead), 0);
    check("rst_tick", int'(oTick), 0);
    check("rst_full", int'(oFull), 0);
    check("w_start_x", int'(x2), 638);
    cyc(4);
    check("first_tick", int'(oTick), 1);
    check("first_x", int'(oX), 241);
    check("first_y", int'(oY), 350);
`ifdef SNAKE_WRAP_EN
    check("w_x", int'(x2), 0);
    check("w_wall", int'(wall2), 0);
`else
    check("w_x", int'(x2), 638);
    check("w_wall", int'(wall2), 1);
`endif
    check("w_y", int'(y2), 350);
    check("w_head", int'(head2), 0);
    check("w_full", int'(full2), 0);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      ticks += int'(tick2);
      if (i == 0) check("tick_width", int'(oTick), 0);
    end
`ifdef SNAKE_WRAP_EN
    check("w_ticks", ticks, 3);
    check("w_x_end", int'(x2), 6);
    check("w_wall_end", int'(wall2), 0);
`else
    check("w_ticks", ticks, 0);
    check("w_x_end", int'(x2), 638);
    check("w_wall_end", int'(wall2), 1);
`endif
    check("x_after_4", int'(oX), 244);

    // speed table: first period always level 0, then by length
    for (int v = 0; v < 6; v++) begin
      iSnakeLength = 8'(vecs[v].len);
      do_reset();
      wait_tick(n);
      check("per_first", n, TP0);
      wait_tick(n);
      check("per_level", n, vecs[v].per);
    end

    // length change mid-period applies only to the next period
    iSnakeLength = 8'd19;
    do_reset();
    cyc(2);
    iSnakeLength = 8'd20;
    wait_tick(n);
    check("mid_cur", n, 2);
    wait_tick(n);
    check("mid_next", n, TP1);
    wait_tick(n);
    check("mid_again", n, TP1);
    iSnakeLength = 8'd0;

    // quick north then west within one period
    do_reset();
    press(2);
    press(1);
    check("nw_full", int'(oFull), 1);
    cyc(2);
    check("nw_t1_tick", int'(oTick), 1);
    check("nw_t1_y", int'(oY), 349);
    check("nw_t1_head", int'(oHead), 2);
    cyc(4);
    check("nw_t2_x", int'(oX), 239);
    check("nw_t2_head", int'(oHead), 1);

    // discards, fill, overflow drop
    do_reset();
    press(1);
    press(0);
    cyc(2);
    check("disc_head", int'(oHead), 0);
    check("disc_x", int'(oX), 241);
    check("disc_full", int'(oFull), 0);
    press(2);
    press(0);
    check("fill_full", int'(oFull), 1);
    press(3);
    cyc(1);
    check("pop1_tick", int'(oTick), 1);
    check("pop1_head", int'(oHead), 2);
    check("pop1_y", int'(oY), 349);
    check("pop1_full", int'(oFull), 0);
    cyc(4);
    check("pop2_head", int'(oHead), 0);
    check("pop2_x", int'(oX), 242);
    cyc(4);
    check("drop_head", int'(oHead), 0);
    check("drop_x", int'(oX), 243);
    check("drop_y", int'(oY), 349);

    // pause, game over, reset
    do_reset();
    cyc(2);
    iPause = 1;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      ticks += int'(oTick);
    end
    check("pause_ticks", ticks, 0);
    check("pause_x", int'(oX), 240);
    iPause = 0;
    wait_tick(n);
    check("resume_lat", n, 3);
    check("resume_x", int'(oX), 241);
    iGameOver = 1;
    cyc(1);
    iGameOver = 0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      ticks += int'(oTick);
    end
    check("halt_ticks", ticks, 0);
    check("halt_x", int'(oX), 241);
    do_reset();
    check("rr_x", int'(oX), 240);
    check("rr_y", int'(oY), 350);
    check("rr_head", int'(oHead), 0);
    wait_tick(n);
    check("rr_period", n, TP0);

    // reset flushes queued turns
    do_reset();
    press(2);
    press(1);
    check("fl_full_pre", int'(oFull), 1);
    do_reset();
    check("fl_full", int'(oFull), 0);
    wait_tick(n);
    check("fl_period", n, TP0);
    check("fl_head", int'(oHead), 0);
    check("fl_x", int'(oX), 241);

    // random run against the model
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        iWest  = ($urandom_range(0, 5) == 0);
        iEast  = ($urandom_range(0, 5) == 0);
        iNorth = ($urandom_range(0, 5) == 0);
        iSouth = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 29) == 0) iPause = ~iPause;
        iGameOver = ($urandom_range(0, 999) == 0);
        if ($urandom_range(0, 49) == 0)
          iSnakeLength = 8'(lens[$urandom_range(0, 5)]);
        cyc(1);
      end
    end
    clr_in();
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snake_motion_ctrl.md
Name: snake_motion_ctrl

Overview:
Parametrised, single-clock successor to the snake head movement block. It generates the movement tick from a length-dependent speed table and buffers turn requests in a small queue, so quick double-turns are not lost. It steps the head coordinate with configurable step size and playfield bounds, and flags wall collisions. It sits between the button debouncers and the body/collision logic and VGA renderer.

Parameters:
COORD_W, 11, coordinate width (bits)
X_MAX, 639, largest legal X coordinate
Y_MAX, 479, largest legal Y coordinate
START_X, 240, X loaded at reset
START_Y, 350, Y loaded at reset
STEP, 1, pixels moved per tick (1..X_MAX and 1..Y_MAX)
LEN_W, 8, width of length input
LEN_TH1, 20, length at which speed level 1 begins
LEN_TH2, 50, length at which speed level 2 begins (LEN_TH2 > LEN_TH1)
PERIOD0, 2000000, clocks per tick at level 0
PERIOD1, 900000, clocks per tick at level 1
PERIOD2, 400000, clocks per tick at level 2
TICK_W, 28, tick counter width (must hold PERIOD0-1)
QDEPTH, 2, turn-queue depth (power of 2, at least 1)

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
iGameOver  in  1  level; forces HALT
iPause  in  1  level; freezes tick counter and motion
iWest/iEast/iNorth/iSouth  in  1 each  direction buttons, level, synchronous to Clock
iSnakeLength  in  LEN_W  current body length
oSnakeLocationX  out  COORD_W  head X
oSnakeLocationY  out  COORD_W  head Y
oHeading  out  2  current heading: 0=East, 1=West, 2=North, 3=South
oIconTick  out  1  one-clock pulse on each movement step
oWallHit  out  1  sticky; set on boundary collision
oQueueFull  out  1  turn queue holds QDEPTH entries

Behaviour:
- Reset (async): X=START_X, Y=START_Y, heading=East, counter=0, queue empty, oIconTick=0, oWallHit=0, state=RUN, speed level=0.
- All sequential logic is on posedge Clock. No derived clocks.
- States:
  - RUN -> PAUSE when iPause=1.
  - PAUSE -> RUN when iPause=0.
  - RUN/PAUSE -> HALT when iGameOver=1 or on a wall hit.
  - HALT exits only through Reset.
- Tick:
  - In RUN, the counter increments each clock.
  - When counter == PERIOD(level)-1: counter clears and oIconTick=1 for exactly one clock. Otherwise oIconTick=0.
  - In PAUSE the counter holds its value. In HALT, oIconTick=0.
- Speed level: level 0 if len<LEN_TH1, level 1 if LEN_TH1<=len<LEN_TH2, otherwise level 2. The level is resampled only on the tick clock, so it applies to the next period.
- Turn capture:
  - Each button is rising-edge detected (registered previous value).
  - Simultaneous edges use priority West>East>South>North; only one request per clock.
  - The reference direction is the last queued entry, or the current heading if the queue is empty. A request equal to or opposite of the reference is discarded.
  - A request is also discarded when the queue is full, or in HALT. Requests are accepted in PAUSE.
- Step, on the tick clock:
  - If the queue is not empty, pop one entry into the heading, then move using the new heading.
  - Only one turn is consumed per tick.
  - A push and a pop in the same clock are both honoured.
- Arithmetic (default build):
  - East: if X+STEP > X_MAX, then X holds, oWallHit=1, state goes to HALT. Otherwise X+=STEP.
  - West: if X < STEP, wall hit. Otherwise X-=STEP.
  - North and South do the same on Y against Y_MAX and 0.
  - The comparison uses COORD_W+1 bits, so no silent overflow.
- oWallHit clears only on Reset.
- iGameOver asserted on the tick clock takes priority: no movement that cycle.
- Reset mid-period: the counter restarts from 0 and the queue is flushed.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- When defined, boundaries wrap instead of colliding:
  - East overflow: X = X+STEP-(X_MAX+1).
  - West underflow: X = X+(X_MAX+1)-STEP.
  - Y wraps the same way.
  - oWallHit is tied to 0 and the state never enters HALT from motion.
- When undefined, the wall-hit behaviour above applies.

Test Plan:
- Params PERIOD0=4, len=0, Reset released → oIconTick every 4 clocks; X goes 240,241,242…; Y stays 350; oHeading=0.
- Within one period, pulse iNorth then iWest, then wait 2 ticks → tick 1: Y=349, heading=2; tick 2: X decremented, heading=1.
- Press iWest while heading East → request discarded, queue stays empty, X keeps incrementing. Fill the queue with QDEPTH valid turns → oQueueFull=1 and an extra valid press is dropped.
- Change len from 19 to 20 mid-period → current period keeps PERIOD0; next period uses PERIOD1.
- START_X=638, STEP=2, heading East:
  - Default build: after 1 tick, X=638, oWallHit=1, no further ticks.
  - With SNAKE_WRAP_EN: X=0, oWallHit=0.
- Assert iPause for 10 clocks, then iGameOver; assert Reset mid-period → pause holds the counter and position; iGameOver stops ticks permanently; Reset restores X=240, Y=350, East, queue empty.
